// File: rtl/lane_serializer_4to1_if.sv
// Handshake and mux-drive bundle for lane_serializer_4to1.
// in_mask exists only when LANE_SERIALIZER_MASK_EN is defined.
interface lane_serializer_4to1_if #(
    parameter int unsigned N = 32
) ();
    logic           in_valid;
    logic           in_ready;
    logic [4*N-1:0] in_data;
`ifdef LANE_SERIALIZER_MASK_EN
    logic [3:0]     in_mask;
`endif
    logic [N-1:0]   I0;
    logic [N-1:0]   I1;
    logic [N-1:0]   I2;
    logic [N-1:0]   I3;
    logic [1:0]     S;
    logic           en;
    logic           lane_valid;
    logic           lane_ready;
    logic           lane_last;
    logic           busy;
    logic           done;

    // The serializer itself.
    modport slave (
        input  in_valid,
        input  in_data,
`ifdef LANE_SERIALIZER_MASK_EN
        input  in_mask,
`endif
        input  lane_ready,
        output in_ready,
        output I0,
        output I1,
        output I2,
        output I3,
        output S,
        output en,
        output lane_valid,
        output lane_last,
        output busy,
        output done
    );

    // Whatever feeds words in and consumes lanes.
    modport master (
        output in_valid,
        output in_data,
`ifdef LANE_SERIALIZER_MASK_EN
        output in_mask,
`endif
        output lane_ready,
        input  in_ready,
        input  I0,
        input  I1,
        input  I2,
        input  I3,
        input  S,
        input  en,
        input  lane_valid,
        input  lane_last,
        input  busy,
        input  done
    );
endinterface

// File: rtl/lane_serializer_4to1.sv
// Captures one 4-lane word and steps the 4:1 mux select through its lanes.
// Optional lane masking is enabled with LANE_SERIALIZER_MASK_EN.
module lane_serializer_4to1 #(
    parameter int unsigned N = 32
) (
    input logic                  clk,
    input logic                  rst,
    lane_serializer_4to1_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e       state_q, state_d;
    logic [1:0]   s_q, s_d;
    logic [N-1:0] lane_q [4];
    logic [N-1:0] lane_d [4];
    logic         done_q, done_d;
    logic [3:0]   cap_mask;
    logic [3:0]   cur_mask;
    logic         last_lane_hit;

`ifdef LANE_SERIALIZER_MASK_EN
    logic [3:0]   mask_q, mask_d;

    assign cap_mask = bus.in_mask;
    assign cur_mask = mask_q;
`else
    assign cap_mask = 4'hF;
    assign cur_mask = 4'hF;
`endif

    function automatic logic [1:0] first_lane(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) r = 2'(k);
        end
        return r;
    endfunction

    function automatic logic [1:0] top_lane(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) r = 2'(k);
        end
        return r;
    endfunction

    // Lowest enabled lane strictly above cur; scanning downward lets the lowest win.
    function automatic logic [1:0] next_lane(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] r;
        r = cur;
        for (int k = 3; k >= 0; k--) begin
            if (m[k] && (k > int'(cur))) r = 2'(k);
        end
        return r;
    endfunction

    assign last_lane_hit = (state_q == StSend) && (s_q == top_lane(cur_mask));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= 2'd0;
            done_q  <= 1'b0;
            for (int k = 0; k < 4; k++) lane_q[k] <= '0;
`ifdef LANE_SERIALIZER_MASK_EN
            mask_q  <= 4'h0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            done_q  <= done_d;
            for (int k = 0; k < 4; k++) lane_q[k] <= lane_d[k];
`ifdef LANE_SERIALIZER_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        done_d  = 1'b0;
        for (int k = 0; k < 4; k++) lane_d[k] = lane_q[k];
`ifdef LANE_SERIALIZER_MASK_EN
        mask_d  = mask_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    for (int unsigned k = 0; k < 4; k++) lane_d[k] = bus.in_data[k*N +: N];
                    s_d = first_lane(cap_mask);
`ifdef LANE_SERIALIZER_MASK_EN
                    mask_d = cap_mask;
`endif
                    // An all-zero mask has nothing to send: finish immediately.
                    if (cap_mask == 4'h0) done_d = 1'b1;
                    else                  state_d = StSend;
                end
            end
            StSend: begin
                if (bus.lane_ready) begin
                    if (last_lane_hit) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        s_d = next_lane(cur_mask, s_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready   = (state_q == StIdle) && !rst;
        bus.lane_valid = (state_q == StSend);
        bus.en         = (state_q == StSend);
        bus.busy       = (state_q == StSend);
        bus.lane_last  = last_lane_hit;
        bus.S          = s_q;
        bus.done       = done_q;
        bus.I0         = lane_q[0];
        bus.I1         = lane_q[1];
        bus.I2         = lane_q[2];
        bus.I3         = lane_q[3];
    end

endmodule

// File: tb/tb_lane_serializer_4to1.sv
// Directed self-checking bench for lane_serializer_4to1.
// Mask scenarios run only when LANE_SERIALIZER_MASK_EN is defined.
module tb_lane_serializer_4to1;
    localparam int unsigned N = 32;
    localparam logic [4*N-1:0] WordA = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    localparam logic [4*N-1:0] WordB = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;

    lane_serializer_4to1_if #(.N(N)) bus ();

    lane_serializer_4to1 #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic check_lane(input string tag, input logic [1:0] exp_s, input logic exp_last);
        check({tag, "_valid"}, N'(bus.lane_valid), 1);
        check({tag, "_en"},    N'(bus.en), 1);
        check({tag, "_busy"},  N'(bus.busy), 1);
        check({tag, "_rdy"},   N'(bus.in_ready), 0);
        check({tag, "_S"},     N'(bus.S), N'(exp_s));
        check({tag, "_last"},  N'(bus.lane_last), N'(exp_last));
        check({tag, "_done"},  N'(bus.done), 0);
    endtask

    task automatic check_data(input string tag, input logic [4*N-1:0] w);
        check({tag, "_I0"}, bus.I0, w[N-1:0]);
        check({tag, "_I1"}, bus.I1, w[2*N-1:N]);
        check({tag, "_I2"}, bus.I2, w[3*N-1:2*N]);
        check({tag, "_I3"}, bus.I3, w[4*N-1:3*N]);
    endtask

    task automatic check_quiet(input string tag, input logic exp_rdy, input logic exp_done);
        check({tag, "_valid"}, N'(bus.lane_valid), 0);
        check({tag, "_en"},    N'(bus.en), 0);
        check({tag, "_busy"},  N'(bus.busy), 0);
        check({tag, "_last"},  N'(bus.lane_last), 0);
        check({tag, "_rdy"},   N'(bus.in_ready), N'(exp_rdy));
        check({tag, "_done"},  N'(bus.done), N'(exp_done));
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = WordA;
        bus.lane_ready = 1'b0;
`ifdef LANE_SERIALIZER_MASK_EN
        bus.in_mask    = 4'hF;
`endif
        // Reset held with in_valid high: nothing captured.
        step();
        step();
        check_quiet("rst", 1'b0, 1'b0);
        check("rst_S", N'(bus.S), 0);
        check_data("rst", '0);

        rst = 1'b0;
        #1;
        check("rel_rdy", N'(bus.in_ready), 1);

        // Full word, lane_ready high; capture at the next edge.
        bus.lane_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_lane($sformatf("full%0d", k), 2'(k), k == 3);
            check_data($sformatf("full%0d", k), WordA);
            step();
        end
        check_quiet("full_end", 1'b1, 1'b1);
        check("full_end_S", N'(bus.S), 3);
        step();
        check("full_done_pulse", N'(bus.done), 0);

        // Back-pressure: three cycles of lane_ready low at S=1.
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check_lane("bp_t1", 2'd0, 1'b0);
        step();
        check_lane("bp_t2", 2'd1, 1'b0);
        bus.lane_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_lane($sformatf("bp_hold%0d", i), 2'd1, 1'b0);
            check("bp_hold_I1", bus.I1, 32'h11111111);
        end
        bus.lane_ready = 1'b1;
        step();
        check_lane("bp_t6", 2'd2, 1'b0);
        step();
        check_lane("bp_t7", 2'd3, 1'b1);
        step();
        check_quiet("bp_t8", 1'b1, 1'b1);
        step();

        // Reset in the middle of a word.
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        check_lane("mid_t3", 2'd2, 1'b0);
        rst = 1'b1;
        step();
        check_quiet("mid_rst", 1'b0, 1'b0);
        check("mid_rst_S", N'(bus.S), 0);
        check_data("mid_rst", '0);
        rst = 1'b0;
        step();
        check_quiet("mid_after", 1'b1, 1'b0);
        bus.in_data  = WordB;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check_lane("mid_new", 2'd0, 1'b0);
        check_data("mid_new", WordB);
        for (int i = 0; i < 4; i++) step();
        check_quiet("mid_new_end", 1'b1, 1'b1);

        // Back-to-back with in_valid held; data changed mid-word must be ignored.
        bus.in_data  = WordA;
        bus.in_valid = 1'b1;
        step();
        check_lane("b2b_t1", 2'd0, 1'b0);
        bus.in_data = WordB;
        step();
        step();
        step();
        check_lane("b2b_t4", 2'd3, 1'b1);
        check_data("b2b_t4", WordA);
        step();
        check_quiet("b2b_t5", 1'b1, 1'b1);
        step();
        check_lane("b2b_t6", 2'd0, 1'b0);
        check_data("b2b_t6", WordB);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_quiet("b2b_drain", 1'b1, 1'b0);

`ifdef LANE_SERIALIZER_MASK_EN
        // Sparse mask: lanes 1 then 3.
        bus.in_mask  = 4'b1010;
        bus.in_data  = WordA;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check_lane("mask_t1", 2'd1, 1'b0);
        step();
        check_lane("mask_t2", 2'd3, 1'b1);
        step();
        check_quiet("mask_t3", 1'b1, 1'b1);
        step();

        // Empty mask: straight to done, never valid.
        bus.in_mask  = 4'b0000;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check_quiet("mask0_t1", 1'b1, 1'b1);
        step();
        check_quiet("mask0_t2", 1'b1, 1'b0);
        bus.in_mask = 4'hF;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
